// File: rtl/telem_ascii_sched.sv
// Round-robin telemetry scheduler: grants one channel, converts its value to
// ASCII through an external converter, then streams 11 characters plus EOL.
module telem_ascii_sched #(
  parameter int          NUM_CH  = 4,
  parameter int          TIMEOUT = 64,
  parameter logic [7:0]  EOL     = 8'h0A
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      req,
  input  logic [32*NUM_CH-1:0]   ch_data,
  output logic [NUM_CH-1:0]      gnt,
  output logic [31:0]            conv_bin,
  output logic                   conv_start,
  input  logic [87:0]            conv_ascii,
  input  logic                   conv_valid,
  input  logic                   conv_busy,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   sched_busy,
  output logic                   timeout_err
);

  localparam int PW = $clog2(NUM_CH);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GRANT = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] SEND  = 3'd4;
  localparam logic [2:0] TERM  = 3'd5;

  logic [2:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [87:0]   sr;
  logic [3:0]    byte_cnt;
  logic [CW-1:0] wait_cnt;

  logic          found;
  logic [PW-1:0] sel;
  logic          res_ok;
  logic          tmo;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    // Walk offsets from high to low so the closest requester after rr_ptr wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  // The first WAIT cycle (wait_cnt == 0) never accepts a result: a valid still
  // high from the previous conversion must not be mistaken for the new one.
  assign res_ok = (state == WAIT) && (wait_cnt != '0) && conv_valid && !conv_busy;
  assign tmo    = (state == WAIT) && !res_ok && (wait_cnt == CW'(TIMEOUT - 1));

  assign gnt         = (state == GRANT && found) ? (NUM_CH'(1) << sel) : '0;
  assign conv_start  = (state == START);
  assign sched_busy  = (state != IDLE);
  assign tx_valid    = (state == SEND) || (state == TERM);
  assign tx_data     = (state == SEND) ? sr[87:80] : (state == TERM) ? EOL : 8'h00;
  assign timeout_err = tmo;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      conv_bin <= '0;
      sr       <= '0;
      byte_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (|req) state <= GRANT;
        GRANT: begin
          if (found) begin
            conv_bin <= ch_data[32*sel +: 32];
            rr_ptr   <= (sel == PW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
            state    <= START;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (res_ok) begin
            sr       <= conv_ascii;
            byte_cnt <= 4'd0;
            state    <= SEND;
          end else if (tmo) begin
            // Preloading the count to 10 makes the lone '?' the last byte.
            sr       <= {8'h3F, 80'h0};
            byte_cnt <= 4'd10;
            state    <= SEND;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SEND: begin
          if (tx_ready) begin
            sr       <= {sr[79:0], 8'h00};
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 4'd10) state <= TERM;
          end
        end
        TERM:    if (tx_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/telem_ascii_sched.md
TELEM_ASCII_SCHED -- requirements
Module: telem_ascii_sched

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of requesting channels (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the maximum cycles to wait for a conversion result.
REQ-003 The block SHALL have parameter EOL, default 8'h0A, giving the byte appended after each record.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_CH  per-channel request level; held until granted.
REQ-007 ch_data  input  32*NUM_CH  signed value per channel; channel i occupies bits [32*i+31:32*i].
REQ-008 gnt  output  NUM_CH  one-hot, one-cycle pulse marking capture of that channel's value.
REQ-009 conv_bin  output  32  signed value presented to the binary-to-ASCII converter.
REQ-010 conv_start  output  1  one-cycle start pulse to the converter.
REQ-011 conv_ascii  input  88  11 ASCII characters from the converter; bits [87:80] are the first character.
REQ-012 conv_valid  input  1  converter result valid.
REQ-013 conv_busy  input  1  converter is working.
REQ-014 tx_data  output  8  byte to the serial transmitter.
REQ-015 tx_valid  output  1  tx_data holds a byte.
REQ-016 tx_ready  input  1  transmitter accepts the byte this cycle.
REQ-017 sched_busy  output  1  high in every state except IDLE.
REQ-018 timeout_err  output  1  one-cycle pulse when a conversion times out.

Function
REQ-019 The FSM SHALL have states IDLE, GRANT, START, WAIT, SEND, TERM.
REQ-020 In IDLE, if any req bit is high, the FSM SHALL go to GRANT on the next edge; otherwise it SHALL stay in IDLE.
REQ-021 In GRANT, the block SHALL select the first requesting channel at or after rr_ptr, searching upward with wrap-around.
REQ-022 In GRANT, the block SHALL capture that channel's ch_data into conv_bin and pulse its gnt bit.
REQ-023 In GRANT, the block SHALL set rr_ptr to the selected index + 1, modulo NUM_CH, and then go to START.
REQ-024 In START, conv_start SHALL be high for exactly one cycle and the FSM SHALL then go to WAIT.
REQ-025 conv_bin SHALL stay constant from GRANT until the FSM returns to IDLE.
REQ-026 WAIT SHALL ignore conv_valid during its first cycle, so that a stale valid from the previous conversion is not used.
REQ-027 From the second WAIT cycle onward, conv_valid=1 with conv_busy=0 SHALL load conv_ascii into an 88-bit shift register.
REQ-028 On that load, the block SHALL clear the 4-bit byte counter and go to SEND.
REQ-029 A cycle counter SHALL run in WAIT; at TIMEOUT cycles without a result, the block SHALL pulse timeout_err.
REQ-030 On timeout, the shift register top byte SHALL be set to 8'h3F ("?") and the FSM SHALL send only that byte, then go to TERM.
REQ-031 If a valid result and the timeout occur in the same cycle, the valid result SHALL win.
REQ-032 In SEND, tx_valid SHALL be 1 and tx_data SHALL equal shift register bits [87:80].
REQ-033 In SEND, on tx_valid && tx_ready the block SHALL shift the register left by 8 and increment the byte counter.
REQ-034 After the 11th accepted byte, the FSM SHALL go to TERM.
REQ-035 tx_data SHALL NOT change while tx_valid=1 and tx_ready=0.
REQ-036 In TERM, tx_data SHALL be EOL with tx_valid=1; on acceptance the FSM SHALL go to IDLE.
REQ-037 A req that stays high through TERM SHALL be served next; no cycle is inserted other than IDLE.
REQ-038 req changes after GRANT SHALL NOT affect the record in progress.
REQ-039 A channel whose req stays high SHALL NOT be granted twice while another channel is requesting.

Reset
REQ-040 While rst is high, the FSM SHALL be in IDLE.
REQ-041 While rst is high, gnt, conv_start, tx_valid, timeout_err and sched_busy SHALL be 0.
REQ-042 While rst is high, conv_bin, tx_data and the shift register SHALL be 0, and rr_ptr SHALL be 0.
REQ-043 rst asserted mid-record SHALL abandon the record; after release, the record SHALL NOT resume and no further bytes SHALL be emitted for it.

Verification
REQ-044 req=4'b0001, ch0=8, converter returns " 0000000008" -> gnt=0001 pulse, one conv_start, bytes 20,30x9,38,0A in order.
REQ-045 req=4'b1111 held for 4 records -> grants in order ch0, ch1, ch2, ch3, each record 12 bytes.
REQ-046 ch1=-10, tx_ready toggling every other cycle -> 12 bytes, no duplicated or dropped byte, tx_data stable while stalled.
REQ-047 Converter never raises conv_valid -> timeout_err pulses at WAIT cycle 64, output 3F,0A, then IDLE.
REQ-048 rst asserted after 5 of 12 bytes -> tx_valid=0 at once, rr_ptr=0, next record starts from ch0.
REQ-049 conv_valid left high from the previous record when START fires -> the first WAIT cycle ignores it and the new result is used.
